// File: rtl/mul_div_unit.sv
// RV32M multiply/divide unit: iterative shift-add multiply and restoring
// divide, one bit per cycle, with a fast path for divide-by-zero/overflow.
module mul_div_unit (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [31:0] operandA,
   input  logic [31:0] operandB,
   input  logic [4:0]  rdIn,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [4:0]  rdOut,
   output logic        writeRegister
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]  state;
   logic [5:0]  cnt;
   logic [2:0]  op;
   logic [31:0] ma;
   logic [31:0] mb;
   logic        negq;
   logic        negr;
   logic [31:0] hi;
   logic [31:0] lo;

   logic        sa;
   logic        sb;
   logic        sgna;
   logic        sgnb;
   logic [31:0] absa;
   logic [31:0] absb;
   logic        divz;
   logic        ovf;
   logic [31:0] fastres;
   logic [32:0] msum;
   logic [32:0] trial;
   logic        dge;
   logic [31:0] ddiff;
   logic [63:0] prod;
   logic [63:0] prodn;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] fin;

   assign sa = (funct3 == 3'b001) | (funct3 == 3'b010)
             | (funct3 == 3'b100) | (funct3 == 3'b110);
   assign sb = (funct3 == 3'b001) | (funct3 == 3'b100)
             | (funct3 == 3'b110);
   assign sgna = sa & operandA[31];
   assign sgnb = sb & operandB[31];
   assign absa = sgna ? -operandA : operandA;
   assign absb = sgnb ? -operandB : operandB;

   assign divz = funct3[2] & (operandB == 32'd0);
   assign ovf  = funct3[2] & ~funct3[0]
               & (operandA == 32'h8000_0000)
               & (operandB == 32'hffff_ffff);
   assign fastres = funct3[1] ? (divz ? operandA : 32'd0)
                              : (divz ? 32'hffff_ffff : 32'h8000_0000);

   // multiply: {hi,lo} holds partial product, multiplier shifts out of lo
   assign msum = {1'b0, hi} + (lo[0] ? {1'b0, ma} : 33'd0);

   // divide: hi is the partial remainder, quotient bits shift into lo
   assign trial = {hi, lo[31]};
   assign dge   = trial >= {1'b0, mb};
   assign ddiff = trial[31:0] - mb;

   assign prod  = {hi, lo};
   assign prodn = negq ? -prod : prod;
   assign quo   = negq ? -lo : lo;
   assign rem   = negr ? -hi : hi;
   assign fin   = op[2] ? (op[1] ? rem : quo)
                        : ((op[1:0] == 2'b00) ? prodn[31:0] : prodn[63:32]);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         cnt    <= '0;
         op     <= '0;
         ma     <= '0;
         mb     <= '0;
         negq   <= 1'b0;
         negr   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         result <= '0;
         rdOut  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  op    <= funct3;
                  rdOut <= rdIn;
                  if (divz | ovf) begin
                     result <= fastres;
                     state  <= DONE;
                  end else begin
                     cnt   <= '0;
                     ma    <= absa;
                     mb    <= absb;
                     negq  <= sgna ^ sgnb;
                     negr  <= sgna;
                     hi    <= '0;
                     lo    <= funct3[2] ? absa : absb;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (cnt == 6'd32) begin
                  result <= fin;
                  state  <= DONE;
               end else begin
                  cnt <= cnt + 6'd1;
                  if (op[2]) begin
                     hi <= dge ? ddiff : trial[31:0];
                     lo <= {lo[30:0], dge};
                  end else begin
                     hi <= msum[32:1];
                     lo <= {msum[0], lo[31:1]};
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy          = (state == CALC);
   assign done          = (state == DONE);
   assign writeRegister = done & (rdOut != 5'd0);

endmodule
